// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
// Holds the arbiter state enum, the owner encoding and the default parameter values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_C = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int DEFAULT_DW       = 8;
    localparam int DEFAULT_AW       = 8;
    localparam int DEFAULT_MAX_HOLD = 4;
    localparam int HOLD_W           = 4;

endpackage

// File: rtl/arb_hold_counter.sv
// rtl/arb_hold_counter.sv - saturating count of consecutive owned cycles
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   clear      restart the count at zero (new owner)
//   enable     one owned cycle elapsed
//   at_max     count has reached MAX_HOLD-1
module arb_hold_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic at_max
);

    localparam logic [HOLD_W-1:0] CNT_MAX = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_max) begin
            count <= count + HOLD_W'(1);
        end
    end

    assign at_max = (count == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory port arbiter with bounded hold time
// Ports:
//   clk, rst                                    clock, asynchronous active-low reset
//   core_req/we/addr/wdata, core_gnt/rvalid     core requester
//   dbg_req/we/addr/wdata, dbg_gnt/rvalid       debug/loader requester
//   mem_addr, mem_wdata, mem_we, mem_rdata      shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int AW       = DEFAULT_AW,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t    state;
    arb_state_t    next_state;
    owner_t        last_owner;
    logic          ready;
    logic          at_max;
    logic          hold_clear;
    logic          hold_en;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;

    // Read data goes straight from memory to the requesters; only the
    // rvalid qualifiers are generated here.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    // ready is low for the first edge after reset release, so no grant can
    // appear before the second rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= OWNER_D;
            ready      <= 1'b0;
        end else begin
            state <= next_state;
            ready <= 1'b1;
            if (next_state == OWN_C && state != OWN_C) begin
                last_owner <= OWNER_C;
            end else if (next_state == OWN_D && state != OWN_D) begin
                last_owner <= OWNER_D;
            end
        end
    end

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_addr   = addr_hold;
        mem_wdata  = wdata_hold;
        case (state)
            IDLE: begin
                if (ready) begin
                    if (core_req && dbg_req) begin
                        next_state = (last_owner == OWNER_C) ? OWN_D : OWN_C;
                    end else if (core_req) begin
                        next_state = OWN_C;
                    end else if (dbg_req) begin
                        next_state = OWN_D;
                    end
                end
            end
            OWN_C: begin
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                if (!core_req) begin
                    next_state = dbg_req ? OWN_D : IDLE;
                end else if (at_max && dbg_req) begin
                    next_state = OWN_D;
                end
            end
            OWN_D: begin
                mem_we    = dbg_we;
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                if (!dbg_req) begin
                    next_state = core_req ? OWN_C : IDLE;
                end else if (at_max && core_req) begin
                    next_state = OWN_C;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign hold_clear = (next_state != state) && (next_state != IDLE);
    assign hold_en    = (state != IDLE);

    arb_hold_counter #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clear (hold_clear),
        .enable(hold_en),
        .at_max(at_max)
    );

    // The port keeps showing the last owned address/data while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rvalid <= 1'b0;
            dbg_rvalid  <= 1'b0;
            addr_hold   <= '0;
            wdata_hold  <= '0;
        end else begin
            core_rvalid <= (state == OWN_C) && !core_we;
            dbg_rvalid  <= (state == OWN_D) && !dbg_we;
            if (state != IDLE) begin
                addr_hold  <= mem_addr;
                wdata_hold <= mem_wdata;
            end
        end
    end

    assign core_gnt = (state == OWN_C);
    assign dbg_gnt  = (state == OWN_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int DW       = 8;
    localparam int AW       = 8;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we, dbg_req, dbg_we;
    logic [AW-1:0] core_addr, dbg_addr, mem_addr;
    logic [DW-1:0] core_wdata, dbg_wdata, mem_wdata, mem_rdata;
    logic          core_gnt, core_rvalid, dbg_gnt, dbg_rvalid, mem_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DW(DW), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous memory: read data appears one cycle after the address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: owner 0=none 1=core 2=debug, held = owned cycles so far.
    int            m_owner, m_last, m_held;
    bit            m_ready, m_crv, m_drv;
    logic [AW-1:0] m_addr_hold;
    logic [DW-1:0] m_wd_hold;

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_held = 0; m_ready = 0;
        m_crv = 0; m_drv = 0; m_addr_hold = '0; m_wd_hold = '0;
    endtask

    task automatic compare_model(input string tag);
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        ewe = 1'b0; ea = m_addr_hold; ewd = m_wd_hold;
        if (m_owner == 1) begin ewe = core_we; ea = core_addr; ewd = core_wdata; end
        if (m_owner == 2) begin ewe = dbg_we;  ea = dbg_addr;  ewd = dbg_wdata;  end
        chk({tag, " core_gnt"},    core_gnt,    32'(m_owner == 1));
        chk({tag, " dbg_gnt"},     dbg_gnt,     32'(m_owner == 2));
        chk({tag, " mem_we"},      mem_we,      32'(ewe));
        chk({tag, " mem_addr"},    mem_addr,    32'(ea));
        chk({tag, " mem_wdata"},   mem_wdata,   32'(ewd));
        chk({tag, " core_rvalid"}, core_rvalid, 32'(m_crv));
        chk({tag, " dbg_rvalid"},  dbg_rvalid,  32'(m_drv));
    endtask

    task automatic model_step();
        int nxt, other;
        bit my_req, ot_req;
        m_crv = (m_owner == 1) && !core_we;
        m_drv = (m_owner == 2) && !dbg_we;
        if (m_owner == 1) begin m_addr_hold = core_addr; m_wd_hold = core_wdata; end
        if (m_owner == 2) begin m_addr_hold = dbg_addr;  m_wd_hold = dbg_wdata;  end
        nxt = m_owner;
        if (!m_ready) begin
            m_ready = 1;
        end else if (m_owner == 0) begin
            if (core_req && dbg_req) nxt = (m_last == 1) ? 2 : 1;
            else if (core_req)      nxt = 1;
            else if (dbg_req)       nxt = 2;
        end else begin
            other  = 3 - m_owner;
            my_req = (m_owner == 1) ? core_req : dbg_req;
            ot_req = (other == 1) ? core_req : dbg_req;
            if (!my_req)                          nxt = ot_req ? other : 0;
            else if (ot_req && m_held >= MAX_HOLD) nxt = other;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_held = 1; m_last = nxt;
        end else if (nxt != 0) begin
            m_held++;
        end
        m_owner = nxt;
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic cycle(input string tag);
        #1;
        compare_model(tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    // Called at a falling edge; returns at a falling edge with rst just released.
    task automatic do_reset();
        rst = 1'b0;
        set_idle_inputs();
        model_reset();
        #1;
        chk("rst core_gnt", core_gnt, 0);
        chk("rst dbg_gnt", dbg_gnt, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rvalid", {core_rvalid, dbg_rvalid}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit         rst_first;
        logic       cr, cw;
        logic [7:0] ca, cd;
        logic       dr, dw;
        logic [7:0] da, dd;
        logic       e_cg, e_dg, e_we;
        logic [7:0] e_addr;
        logic       e_crv, e_drv;
        bit         chk_rd;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic cr, logic cw, logic [7:0] ca, logic [7:0] cd,
                                logic dr, logic dw, logic [7:0] da, logic [7:0] dd,
                                logic cg, logic dg, logic we, logic [7:0] a,
                                logic crv, logic drv, bit crd, logic [7:0] rd);
        vec_t v;
        v.rst_first = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.e_cg = cg; v.e_dg = dg; v.e_we = we; v.e_addr = a;
        v.e_crv = crv; v.e_drv = drv; v.chk_rd = crd; v.e_rd = rd;
        return v;
    endfunction

    initial begin
        rst = 1'b0;
        set_idle_inputs();
        model_reset();

        // Core alone after reset: grant from the second edge, late read completes.
        tbl.push_back(mk(1, 1,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3C, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3C, 1,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h3C, 1,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h3C, 1,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h3C,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h3C, 0,0, 0,8'h00));
        // Both requesting from reset: core 4 cycles, debug 4 cycles, core again.
        tbl.push_back(mk(1, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 1,0,0,8'h11, 0,0, 0,8'h00));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 1,0,0,8'h11, 1,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 0,1,0,8'h22, 1,0, 0,8'h00));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 0,1,0,8'h22, 0,1, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 1,0,0,8'h11, 0,1, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h11,8'h00, 1,0,8'h22,8'h00, 1,0,0,8'h11, 1,0, 0,8'h00));
        // Debug write 0x10=0xA5 then core read of 0x10; each drop hands over without idle.
        tbl.push_back(mk(1, 0,0,8'h00,8'h00, 1,1,8'h10,8'hA5, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h00,8'h00, 1,1,8'h10,8'hA5, 0,0,0,8'h00, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 1,0,8'h10,8'h00, 0,1,8'h10,8'hA5, 0,1,1,8'h10, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,0,8'h10, 0,0, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h20,8'h00, 0,1,0,8'h20, 1,0, 1,8'hA5));
        tbl.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h20, 0,1, 0,8'h00));
        tbl.push_back(mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h20, 0,0, 0,8'h00));

        @(negedge clk);
        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            if (tbl[i].rst_first) do_reset();
            core_req = tbl[i].cr; core_we = tbl[i].cw; core_addr = tbl[i].ca; core_wdata = tbl[i].cd;
            dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dd;
            #1;
            chk({tag, " tbl core_gnt"}, core_gnt, 32'(tbl[i].e_cg));
            chk({tag, " tbl dbg_gnt"}, dbg_gnt, 32'(tbl[i].e_dg));
            chk({tag, " tbl mem_we"}, mem_we, 32'(tbl[i].e_we));
            chk({tag, " tbl mem_addr"}, mem_addr, 32'(tbl[i].e_addr));
            chk({tag, " tbl core_rvalid"}, core_rvalid, 32'(tbl[i].e_crv));
            chk({tag, " tbl dbg_rvalid"}, dbg_rvalid, 32'(tbl[i].e_drv));
            if (tbl[i].chk_rd) chk({tag, " tbl mem_rdata"}, mem_rdata, 32'(tbl[i].e_rd));
            cycle(tag);
        end

        // Core alone for 22 cycles: never released.
        do_reset();
        core_req = 1'b1; core_addr = 8'h55;
        for (int k = 0; k < 22; k++) begin
            core_wdata = 8'(k);
            core_we = k[0];
            cycle("hold");
            if (k >= 1) chk($sformatf("hold core_gnt k%0d", k), core_gnt, 1);
        end

        // Reset asserted during a granted write, with a read pulse pending.
        do_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h40;
        cycle("abort0");
        cycle("abort1");
        cycle("abort2");
        core_we = 1'b1; core_wdata = 8'h77;
        #1;
        chk("abort pre mem_we", mem_we, 1);
        chk("abort pre core_rvalid", core_rvalid, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("abort mem_we", mem_we, 0);
        chk("abort grants", {core_gnt, dbg_gnt}, 0);
        chk("abort rvalid", {core_rvalid, dbg_rvalid}, 0);
        chk("abort mem_addr", mem_addr, 0);
        chk("abort mem_wdata", mem_wdata, 0);
        @(negedge clk);

        // Randomised traffic against the reference model.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            int pc, pd;
            pc = ((k / 100) % 2 == 0) ? 75 : 40;
            pd = ((k / 150) % 2 == 0) ? 60 : 25;
            core_req   = ($urandom_range(0, 99) < pc);
            dbg_req    = ($urandom_range(0, 99) < pd);
            core_we    = $urandom_range(0, 1) == 1;
            dbg_we     = $urandom_range(0, 1) == 1;
            core_addr  = 8'($urandom);
            dbg_addr   = 8'($urandom);
            core_wdata = 8'($urandom);
            dbg_wdata  = 8'($urandom);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
